// File: rtl/midi_encoder_if.sv
// rtl/midi_encoder_if.sv - channel-voice event handshake between synth control logic and the MIDI encoder
interface midi_encoder_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_type;
    logic [3:0] ev_chan;
    logic [6:0] ev_d1;
    logic [6:0] ev_d2;

    modport master (
        output ev_valid,
        output ev_type,
        output ev_chan,
        output ev_d1,
        output ev_d2,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_type,
        input  ev_chan,
        input  ev_d1,
        input  ev_d2,
        output ev_ready
    );
endinterface

// File: rtl/midi_encoder.sv
// rtl/midi_encoder.sv - 8N1 MIDI OUT transmitter; running status compression when MIDI_RUNNING_STATUS_EN is defined
module midi_encoder #(
    parameter int CLKS_PER_BIT = 800
) (
    input  logic          CLOCK_25,
    input  logic          iRST_N,
    midi_encoder_if.slave ev,
    output logic          midi_txd,
    output logic          tx_busy,
    output logic          ev_drop,
    output logic [15:0]   bytes_sent
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST_CLK = TW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [7:0]    cap_status;
    logic [6:0]    cap_d1;
    logic [6:0]    cap_d2;
    logic          cap_short;

    logic [3:0]    nibble;
    logic          type_ok;
    logic [7:0]    new_status;
    logic          skip_status;
    logic [7:0]    cur_byte;
    logic          bit_end;
    logic          last_byte;

    // Status nibble lookup; types 5-7 are flagged invalid
    always_comb begin
        nibble  = 4'h0;
        type_ok = 1'b1;
        case (ev.ev_type)
            3'd0:    nibble = 4'h8;
            3'd1:    nibble = 4'h9;
            3'd2:    nibble = 4'hB;
            3'd3:    nibble = 4'hE;
            3'd4:    nibble = 4'hC;
            default: type_ok = 1'b0;
        endcase
    end

    assign new_status = {nibble, ev.ev_chan};

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status;
    logic       last_valid;

    assign skip_status = last_valid && (new_status == last_status);

    // Remember the status byte only once it has fully left the wire
    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) begin
            last_status <= 8'h00;
            last_valid  <= 1'b0;
        end else if (state == STOP && bit_end && byte_idx == 2'd0) begin
            last_status <= cap_status;
            last_valid  <= 1'b1;
        end
    end
`else
    assign skip_status = 1'b0;
`endif

    // Byte currently on the wire: status, then data bytes with bit 7 clear
    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = cap_status;
            2'd1:    cur_byte = {1'b0, cap_d1};
            default: cur_byte = {1'b0, cap_d2};
        endcase
    end

    assign bit_end     = (timer == LAST_CLK);
    assign last_byte   = (byte_idx == (cap_short ? 2'd1 : 2'd2));
    assign ev.ev_ready = (state == IDLE);
    assign tx_busy     = (state != IDLE);

    // Transmit FSM; the line is registered and changes on the same edge as the state
    always_ff @(posedge CLOCK_25 or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= 3'd0;
            byte_idx   <= 2'd0;
            cap_status <= 8'h00;
            cap_d1     <= 7'h00;
            cap_d2     <= 7'h00;
            cap_short  <= 1'b0;
            midi_txd   <= 1'b1;
            ev_drop    <= 1'b0;
            bytes_sent <= 16'h0000;
        end else begin
            ev_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev.ev_valid) begin
                        if (!type_ok) begin
                            ev_drop <= 1'b1;
                        end else begin
                            cap_status <= new_status;
                            cap_d1     <= ev.ev_d1;
                            cap_d2     <= ev.ev_d2;
                            cap_short  <= (ev.ev_type == 3'd4);
                            byte_idx   <= skip_status ? 2'd1 : 2'd0;
                            timer      <= '0;
                            state      <= START;
                            midi_txd   <= 1'b0;
                        end
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer    <= '0;
                        bit_idx  <= 3'd0;
                        midi_txd <= cur_byte[0];
                        state    <= DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            midi_txd <= 1'b1;
                            state    <= STOP;
                        end else begin
                            bit_idx  <= bit_idx + 3'd1;
                            midi_txd <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer      <= '0;
                        bytes_sent <= bytes_sent + 16'd1;
                        if (last_byte) begin
                            midi_txd <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            midi_txd <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    midi_txd <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_midi_encoder.sv
// tb/tb_midi_encoder.sv - directed self-checking bench for midi_encoder
module tb_midi_encoder;
    localparam int CPB = 16;

    logic        CLOCK_25 = 1'b0;
    logic        iRST_N   = 1'b0;
    logic        midi_txd;
    logic        tx_busy;
    logic        ev_drop;
    logic [15:0] bytes_sent;

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    logic [15:0] exp_bytes = 16'h0000;

    midi_encoder_if ev_bus ();

    midi_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK_25   (CLOCK_25),
        .iRST_N     (iRST_N),
        .ev         (ev_bus),
        .midi_txd   (midi_txd),
        .tx_busy    (tx_busy),
        .ev_drop    (ev_drop),
        .bytes_sent (bytes_sent)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    always @(posedge CLOCK_25) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send_ev(input logic [2:0] t, input logic [3:0] c, input logic [6:0] a,
                           input logic [6:0] b, input bit hold, output int acc);
        @(negedge CLOCK_25);
        checks++;
        if (ev_bus.ev_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_send actual=%b required=1", ev_bus.ev_ready);
        end
        checks++;
        if (midi_txd !== 1'b1) begin
            failures++;
            $display("FAIL line_idle_before_accept actual=%b required=1", midi_txd);
        end
        ev_bus.ev_type  = t;
        ev_bus.ev_chan  = c;
        ev_bus.ev_d1    = a;
        ev_bus.ev_d2    = b;
        ev_bus.ev_valid = 1'b1;
        @(negedge CLOCK_25);
        acc = cyc;
        if (!hold) ev_bus.ev_valid = 1'b0;
    endtask

    task automatic rx_byte(output logic [7:0] b, output int s, output bit ok, output logic stop);
        ok = 1'b0;
        s = 0;
        b = 8'h00;
        stop = 1'bx;
        for (int i = 0; i < 12 * CPB; i++) begin
            if (midi_txd === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLOCK_25);
        end
        if (ok) begin
            s = cyc;
            repeat (CPB / 2) @(negedge CLOCK_25);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge CLOCK_25);
                b[k] = midi_txd;
            end
            repeat (CPB) @(negedge CLOCK_25);
            stop = midi_txd;
            repeat (CPB / 2) @(negedge CLOCK_25);
        end
    endtask

    task automatic recv_msg(input string name, input int n, input logic [23:0] msg,
                            input int acc, output int last_s);
        logic [7:0] b;
        logic       stop;
        int         s;
        int         exp_s;
        bit         ok;
        exp_s  = acc;
        last_s = 0;
        for (int k = 0; k < n; k++) begin
            rx_byte(b, s, ok, stop);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s_timeout byte=%0d no start bit seen", name, k);
                return;
            end
            checks++;
            if (b !== msg[23 - 8 * k -: 8]) begin
                failures++;
                $display("FAIL %s_data byte=%0d actual=%h required=%h", name, k, b, msg[23 - 8 * k -: 8]);
            end
            checks++;
            if (s !== exp_s) begin
                failures++;
                $display("FAIL %s_start_cycle byte=%0d actual=%0d required=%0d", name, k, s, exp_s);
            end
            checks++;
            if (stop !== 1'b1) begin
                failures++;
                $display("FAIL %s_stop_bit byte=%0d actual=%b required=1", name, k, stop);
            end
            exp_bytes = exp_bytes + 16'd1;
            checks++;
            if (bytes_sent !== exp_bytes) begin
                failures++;
                $display("FAIL %s_bytes_sent byte=%0d actual=%h required=%h", name, k, bytes_sent, exp_bytes);
            end
            exp_s  = s + 10 * CPB;
            last_s = s;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge CLOCK_25);
        checks++;
        if (midi_txd !== 1'b1) begin failures++; $display("FAIL reset_txd actual=%b required=1", midi_txd); end
        checks++;
        if (ev_bus.ev_ready !== 1'b1) begin failures++; $display("FAIL reset_ready actual=%b required=1", ev_bus.ev_ready); end
        checks++;
        if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", tx_busy); end
        checks++;
        if (ev_drop !== 1'b0) begin failures++; $display("FAIL reset_drop actual=%b required=0", ev_drop); end
        checks++;
        if (bytes_sent !== 16'h0000) begin failures++; $display("FAIL reset_bytes actual=%h required=0000", bytes_sent); end
        iRST_N = 1'b1;
    endtask

    task automatic test_reset_mid;
        int acc;
        int ls;
        send_ev(3'd1, 4'd0, 7'h3C, 7'h64, 1'b0, acc);
        recv_msg("reset_mid", 1, {8'h90, 16'h0000}, acc, ls);
        repeat (2 * CPB + CPB / 2) @(negedge CLOCK_25);
        checks++;
        if (midi_txd !== 1'b0) begin failures++; $display("FAIL reset_mid_line_low actual=%b required=0", midi_txd); end
        iRST_N = 1'b0;
        #1;
        checks++;
        if (midi_txd !== 1'b1) begin failures++; $display("FAIL reset_mid_txd actual=%b required=1", midi_txd); end
        checks++;
        if (ev_bus.ev_ready !== 1'b1) begin failures++; $display("FAIL reset_mid_ready actual=%b required=1", ev_bus.ev_ready); end
        checks++;
        if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy actual=%b required=0", tx_busy); end
        checks++;
        if (bytes_sent !== 16'h0000) begin failures++; $display("FAIL reset_mid_bytes actual=%h required=0000", bytes_sent); end
        exp_bytes = 16'h0000;
        @(negedge CLOCK_25);
        iRST_N = 1'b1;
    endtask

    task automatic test_note_on;
        int acc;
        int ls;
        send_ev(3'd1, 4'd0, 7'h3C, 7'h64, 1'b0, acc);
        checks++;
        if (tx_busy !== 1'b1) begin failures++; $display("FAIL note_on_busy actual=%b required=1", tx_busy); end
        recv_msg("note_on", 3, {8'h90, 8'h3C, 8'h64}, acc, ls);
        checks++;
        if (ev_bus.ev_ready !== 1'b1) begin failures++; $display("FAIL note_on_ready_end actual=%b required=1", ev_bus.ev_ready); end
        checks++;
        if (bytes_sent !== 16'd3) begin failures++; $display("FAIL note_on_count actual=%0d required=3", bytes_sent); end
    endtask

    task automatic test_running_status;
        int acc;
        int ls;
        send_ev(3'd1, 4'd0, 7'h40, 7'h00, 1'b0, acc);
`ifdef MIDI_RUNNING_STATUS_EN
        recv_msg("rs_note", 2, {8'h40, 8'h00, 8'h00}, acc, ls);
`else
        recv_msg("rs_note", 3, {8'h90, 8'h40, 8'h00}, acc, ls);
`endif
        send_ev(3'd2, 4'd1, 7'h7B, 7'h00, 1'b0, acc);
        recv_msg("rs_cc", 3, {8'hB1, 8'h7B, 8'h00}, acc, ls);
        checks++;
`ifdef MIDI_RUNNING_STATUS_EN
        if (bytes_sent !== 16'd8) begin failures++; $display("FAIL rs_count actual=%0d required=8", bytes_sent); end
`else
        if (bytes_sent !== 16'd9) begin failures++; $display("FAIL rs_count actual=%0d required=9", bytes_sent); end
`endif
    endtask

    task automatic test_back_to_back;
        int acc;
        int ls;
        send_ev(3'd4, 4'hF, 7'h05, 7'h55, 1'b1, acc);
        ev_bus.ev_type = 3'd3;
        ev_bus.ev_chan = 4'd2;
        ev_bus.ev_d1   = 7'h00;
        ev_bus.ev_d2   = 7'h40;
        recv_msg("b2b_pc", 2, {8'hCF, 8'h05, 8'h00}, acc, ls);
        checks++;
        if (ev_bus.ev_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_idle actual=%b required=1", ev_bus.ev_ready); end
        @(negedge CLOCK_25);
        ev_bus.ev_valid = 1'b0;
        recv_msg("b2b_pb", 3, {8'hE2, 8'h00, 8'h40}, ls + 10 * CPB + 1, ls);
    endtask

    task automatic test_invalid;
        int  acc;
        int  ls;
        bit  bad;
        for (int r = 0; r < 2; r++) begin
            send_ev((r == 0) ? 3'd6 : 3'd7, 4'd0, 7'h11, 7'h22, 1'b0, acc);
            checks++;
            if (ev_drop !== 1'b1) begin failures++; $display("FAIL invalid_drop_pulse round=%0d actual=%b required=1", r, ev_drop); end
            bad = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge CLOCK_25);
                if (ev_drop !== 1'b0 || midi_txd !== 1'b1 || tx_busy !== 1'b0 || bytes_sent !== exp_bytes) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL invalid_quiet round=%0d drop=%b txd=%b busy=%b bytes=%h required drop=0 txd=1 busy=0 bytes=%h",
                         r, ev_drop, midi_txd, tx_busy, bytes_sent, exp_bytes);
            end
            send_ev(3'd1, 4'd0, 7'h3C, 7'h64, 1'b0, acc);
`ifdef MIDI_RUNNING_STATUS_EN
            if (r == 1) recv_msg("invalid_note", 2, {8'h3C, 8'h64, 8'h00}, acc, ls);
            else        recv_msg("invalid_note", 3, {8'h90, 8'h3C, 8'h64}, acc, ls);
`else
            recv_msg("invalid_note", 3, {8'h90, 8'h3C, 8'h64}, acc, ls);
`endif
        end
    endtask

    task automatic test_wrap;
        int acc;
        int ls;
        @(negedge CLOCK_25);
        force dut.bytes_sent = 16'hFFFE;
        @(negedge CLOCK_25);
        release dut.bytes_sent;
        exp_bytes = 16'hFFFE;
        send_ev(3'd2, 4'd3, 7'h10, 7'h20, 1'b0, acc);
        recv_msg("wrap", 3, {8'hB3, 8'h10, 8'h20}, acc, ls);
        checks++;
        if (bytes_sent !== 16'h0001) begin failures++; $display("FAIL wrap_final actual=%h required=0001", bytes_sent); end
    endtask

    initial begin
        ev_bus.ev_valid = 1'b0;
        ev_bus.ev_type  = 3'd0;
        ev_bus.ev_chan  = 4'd0;
        ev_bus.ev_d1    = 7'h00;
        ev_bus.ev_d2    = 7'h00;
        test_reset();
        test_reset_mid();
        test_note_on();
        test_running_status();
        test_back_to_back();
        test_invalid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
